stage_fetch: RTL and testbench
==============================

Name: stage_fetch

Overview:
- First pipeline stage plus IF/ID register. Holds the PC and fetches one instruction per request from instruction memory over a req/ready handshake.
- Presents instruction, PC, ROB allocate index, exception vector and supervisor mode to the decode stage.
- Honours hazard stalls from decode and branch/exception redirects from later stages.
- Drains in-flight fetches after a flush so stale instructions never reach decode.

Parameters:
- RESET_PC, 32'h0000_1000, PC loaded on reset.
- EXC_HANDLER_PC, 32'h0000_2000, PC loaded on exception redirect.
- ROB_IDX_W, 4, width of ROB index counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- in_pc_write_disable  in  1  hazard stall from decode: hold PC.
- in_IFID_write_disable  in  1  hazard stall from decode: hold IF/ID.
- in_redirect  in  1  taken branch/jump from MEM; flush.
- in_redirect_pc  in  32  redirect target.
- in_exception  in  1  exception commit from ROB; flush, enter supervisor.
- in_sret  in  1  return from supervisor; flush to in_redirect_pc, leave supervisor.
- in_flush_rob_idx  in  ROB_IDX_W  ROB index to restart allocation from on any flush.
- out_imem_req  out  1  fetch request.
- out_imem_addr  out  32  fetch address.
- in_imem_ready  in  1  one-cycle pulse, data valid.
- in_imem_data  in  32  fetched instruction.
- out_instruction  out  32  IF/ID instruction.
- out_PC  out  32  IF/ID PC.
- out_complete_idx  out  ROB_IDX_W  ROB index tagged on instruction.
- out_exception_vector  out  3  fetch exception code.
- out_supervisor_mode  out  1  current privilege.
- out_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=FETCH.
  - out_instruction=32'h0000_0013 (NOP), out_PC=0, out_complete_idx=0, out_exception_vector=0, out_valid=0.
  - out_supervisor_mode=1, out_imem_req=0, skid buffer empty.
  - Reset mid-request drops it; memory must tolerate an abandoned request.
- stall = in_pc_write_disable | in_IFID_write_disable.
  - IF/ID registers and pc hold while stall=1.
- States:
  - FETCH:
    - if pc[1:0]!=0: no request; when !stall, load IF/ID with NOP, out_PC=pc, vector=EXC_FETCH_MISALIGNED, valid=1; go FAULT.
    - else: out_imem_req=1, addr=pc; go WAIT.
  - WAIT:
    - req held high, addr stable, until in_imem_ready.
    - on ready & !stall: IF/ID<=data, out_PC=pc, vector=0, valid=1, idx<=idx+1 (wraps mod 2^ROB_IDX_W); pc<=pc+4; go FETCH.
    - on ready & stall: data into skid buffer; go HOLD.
  - HOLD:
    - req=0.
    - when stall drops: skid buffer -> IF/ID, pc<=pc+4, idx<=idx+1; go FETCH.
  - DRAIN:
    - req held with the old address until ready.
    - response discarded; go FETCH.
  - FAULT:
    - req=0; wait for flush.
- out_complete_idx is the index of the instruction in IF/ID. The counter advances once per delivered instruction.
- Minimum latency: request in cycle N, ready in N+k, instruction in IF/ID after edge N+k. Back-to-back fetch gives 1 instruction per 2 cycles when k=1 (FETCH→WAIT).
- Flush (any of in_exception, in_redirect, in_sret), priority exception > sret > redirect:
  - pc <= EXC_HANDLER_PC (exception) or in_redirect_pc.
  - IF/ID <= NOP, valid=0, vector=0; idx <= in_flush_rob_idx; skid buffer cleared.
  - exception sets supervisor=1; sret clears it.
  - Next state is DRAIN if currently in WAIT and ready not asserted this cycle, else FETCH.
  - Flush overrides stall.
  - Flush coincident with ready: the response is discarded.
- in_IFID_write_disable without in_pc_write_disable is treated as a full stall; no instruction is dropped or duplicated.

Decomposition:
- Shared package (alongside defines2):
  - NOP_INSTR = 32'h0000_0013.
  - EXC_NONE=3'b000, EXC_FETCH_MISALIGNED=3'b001.
  - fetch state enum {FETCH, WAIT, HOLD, DRAIN, FAULT}.
- One sub-module fetch_skid_buffer: 1-entry buffer holding instruction+PC, with load/clear/valid.

Test Plan:
- Reset release, memory ready one cycle after each req, no stalls:
  - addrs 0x1000, 0x1004, 0x1008 issued.
  - IF/ID shows those PCs with idx 1, 2, 3 and valid=1.
  - out_supervisor_mode=1 throughout.
- Stall high for 3 cycles while ready arrives with 0x00500093:
  - IF/ID unchanged during the stall, state HOLD.
  - 0x00500093 appears the cycle after stall drops; no duplicate; pc advances once.
- in_redirect to 0x1100 while in WAIT (ready 2 cycles later):
  - IF/ID becomes NOP/valid=0.
  - Late response discarded; next req addr=0x1100; idx=in_flush_rob_idx.
- in_redirect_pc=0x1002:
  - no imem req.
  - IF/ID shows PC 0x1002, vector 3'b001, valid=1.
  - FAULT held until in_exception, then req at 0x2000 with supervisor=1.
- in_exception and in_redirect (target 0x3000) in same cycle:
  - pc=0x2000, supervisor=1.
  - Then in_sret with target 0x3000 → req 0x3000, supervisor=0.
- Reset asserted asynchronously mid-WAIT:
  - outputs go to reset values immediately (before next edge); req=0.
  - After release, first req is 0x1000.

Source files
------------

// File: rtl/stage_fetch_pkg.sv
// Shared constants for the fetch stage: NOP encoding, fetch exception codes, FSM state encodings.
// Pure declarations; no logic.
package stage_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] EXC_NONE             = 3'b000;
    localparam logic [2:0] EXC_FETCH_MISALIGNED = 3'b001;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH = 3'd0;
    localparam fetch_state_t ST_WAIT  = 3'd1;
    localparam fetch_state_t ST_HOLD  = 3'd2;
    localparam fetch_state_t ST_DRAIN = 3'd3;
    localparam fetch_state_t ST_FAULT = 3'd4;

endpackage

// File: rtl/stage_fetch_skid_buffer.sv
// One-entry holding register for an instruction+PC that returned while decode was stalled.
// Loads on the edge after load=1; clear wins over load; contents visible on the next cycle.
module fetch_skid_buffer
    import stage_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        vld,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld   <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage + IF/ID register: one outstanding imem request, result in IF/ID the edge after ready.
// Decode stalls park a returning instruction in the skid buffer; flushes drain any in-flight request.
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_1000,
    parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_2000,
    parameter int          ROB_IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_pc_write_disable,
    input  logic                 in_IFID_write_disable,
    input  logic                 in_redirect,
    input  logic [31:0]          in_redirect_pc,
    input  logic                 in_exception,
    input  logic                 in_sret,
    input  logic [ROB_IDX_W-1:0] in_flush_rob_idx,
    output logic                 out_imem_req,
    output logic [31:0]          out_imem_addr,
    input  logic                 in_imem_ready,
    input  logic [31:0]          in_imem_data,
    output logic [31:0]          out_instruction,
    output logic [31:0]          out_PC,
    output logic [ROB_IDX_W-1:0] out_complete_idx,
    output logic [2:0]           out_exception_vector,
    output logic                 out_supervisor_mode,
    output logic                 out_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, req_addr;
    logic         started;
    logic         stall, flush, misaligned;
    logic         issue, deliver_mem, deliver_skid, park, fault_load;
    logic         skid_vld;
    logic [31:0]  skid_instr, skid_pc;

    assign stall      = in_pc_write_disable | in_IFID_write_disable;
    assign flush      = in_exception | in_sret | in_redirect;
    assign misaligned = (pc[1:0] != 2'b00);

    always_comb begin
        issue        = 1'b0;
        deliver_mem  = 1'b0;
        deliver_skid = 1'b0;
        park         = 1'b0;
        fault_load   = 1'b0;
        // A flush in FETCH suppresses the request so no response can belong to the old stream.
        case (state)
            ST_FETCH: if (started && !flush) begin
                if (misaligned) fault_load = !stall;
                else            issue      = 1'b1;
            end
            ST_WAIT: if (in_imem_ready && !flush) begin
                park        = stall;
                deliver_mem = !stall;
            end
            ST_HOLD: deliver_skid = skid_vld && !stall && !flush;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            // A request still outstanding (WAIT or DRAIN) must be drained before refetching.
            state_nxt = ((state == ST_WAIT || state == ST_DRAIN) && !in_imem_ready) ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: if (issue) state_nxt = ST_WAIT;
                          else if (fault_load) state_nxt = ST_FAULT;
                ST_WAIT:  if (in_imem_ready) state_nxt = park ? ST_HOLD : ST_FETCH;
                ST_HOLD:  if (deliver_skid) state_nxt = ST_FETCH;
                ST_DRAIN: if (in_imem_ready) state_nxt = ST_FETCH;
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_FETCH;
            endcase
        end
    end

    assign out_imem_req  = issue || (state == ST_WAIT) || (state == ST_DRAIN);
    assign out_imem_addr = (state == ST_FETCH) ? pc : req_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= ST_FETCH;
            started              <= 1'b0;
            pc                   <= RESET_PC;
            req_addr             <= RESET_PC;
            out_instruction      <= NOP_INSTR;
            out_PC               <= '0;
            out_complete_idx     <= '0;
            out_exception_vector <= EXC_NONE;
            out_valid            <= 1'b0;
            out_supervisor_mode  <= 1'b1;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (issue) req_addr <= pc;
            if (flush) begin
                pc                   <= in_exception ? EXC_HANDLER_PC : in_redirect_pc;
                out_instruction      <= NOP_INSTR;
                out_exception_vector <= EXC_NONE;
                out_valid            <= 1'b0;
                out_complete_idx     <= in_flush_rob_idx;
            end else if (deliver_mem || deliver_skid) begin
                out_instruction      <= deliver_mem ? in_imem_data : skid_instr;
                out_PC               <= deliver_mem ? pc : skid_pc;
                out_exception_vector <= EXC_NONE;
                out_valid            <= 1'b1;
                out_complete_idx     <= out_complete_idx + 1'b1;
                pc                   <= pc + 32'd4;
            end else if (fault_load) begin
                out_instruction      <= NOP_INSTR;
                out_PC               <= pc;
                out_exception_vector <= EXC_FETCH_MISALIGNED;
                out_valid            <= 1'b1;
            end
            if (in_exception)  out_supervisor_mode <= 1'b1;
            else if (in_sret)  out_supervisor_mode <= 1'b0;
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (reset),
        .load       (park),
        .clear      (flush),
        .load_instr (in_imem_data),
        .load_pc    (pc),
        .vld        (skid_vld),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: request/response-level model checked every cycle plus literal pins.
module tb_stage_fetch;
    import stage_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_pc_write_disable, in_IFID_write_disable;
    logic        in_redirect, in_exception, in_sret;
    logic [31:0] in_redirect_pc;
    logic [3:0]  in_flush_rob_idx;
    logic        out_imem_req;
    logic [31:0] out_imem_addr;
    logic        in_imem_ready;
    logic [31:0] in_imem_data;
    logic [31:0] out_instruction, out_PC;
    logic [3:0]  out_complete_idx;
    logic [2:0]  out_exception_vector;
    logic        out_supervisor_mode, out_valid;

    always #5 clk = ~clk;

    stage_fetch dut (
        .clk(clk), .reset(reset),
        .in_pc_write_disable(in_pc_write_disable), .in_IFID_write_disable(in_IFID_write_disable),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .in_exception(in_exception), .in_sret(in_sret), .in_flush_rob_idx(in_flush_rob_idx),
        .out_imem_req(out_imem_req), .out_imem_addr(out_imem_addr),
        .in_imem_ready(in_imem_ready), .in_imem_data(in_imem_data),
        .out_instruction(out_instruction), .out_PC(out_PC), .out_complete_idx(out_complete_idx),
        .out_exception_vector(out_exception_vector), .out_supervisor_mode(out_supervisor_mode),
        .out_valid(out_valid)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: fixed latency per request, one request at a time.
    int          lat = 1;
    int          cnt = 0;
    logic        busy = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] ovr_addr = 32'h0000_100C;
    logic [31:0] ovr_data = 32'h0050_0093;
    logic [31:0] req_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ovr_addr) return ovr_data;
        return {a[15:0], 16'h0513};
    endfunction

    initial begin
        in_imem_ready = 1'b0;
        in_imem_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                busy = 1'b0; in_imem_ready = 1'b0;
            end else if (in_imem_ready) begin
                in_imem_ready = 1'b0; busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    in_imem_ready = 1'b1;
                    in_imem_data  = mem_word(mem_addr);
                end
            end
            @(negedge clk);
            if (reset && !busy && out_imem_req) begin
                busy = 1'b1; cnt = lat; mem_addr = out_imem_addr;
                req_log.push_back(out_imem_addr);
            end
        end
    end

    // Model: tracks whether a fetch is outstanding, discarded, parked or faulted.
    logic        m_started, m_inflight, m_discard, m_pend, m_fault;
    logic [31:0] m_pc, m_addr, m_pend_instr;
    logic [31:0] m_instr, m_ifpc;
    logic [3:0]  m_idx;
    logic [2:0]  m_vec;
    logic        m_valid, m_sup, m_stall;

    task model_deliver(input logic [31:0] d);
        m_instr = d; m_ifpc = m_pc; m_vec = EXC_NONE; m_valid = 1'b1;
        m_idx = m_idx + 4'd1; m_pc = m_pc + 32'd4;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_started = 0; m_inflight = 0; m_discard = 0; m_pend = 0; m_fault = 0;
            m_pc = 32'h1000; m_addr = 0; m_pend_instr = 0;
            m_instr = NOP_INSTR; m_ifpc = 0; m_idx = 0; m_vec = 0; m_valid = 0; m_sup = 1;
        end else begin
            m_stall = in_pc_write_disable | in_IFID_write_disable;
            if (in_exception | in_sret | in_redirect) begin
                m_pc = in_exception ? 32'h2000 : in_redirect_pc;
                m_instr = NOP_INSTR; m_valid = 0; m_vec = 0; m_idx = in_flush_rob_idx;
                m_pend = 0; m_fault = 0;
                if (in_exception) m_sup = 1; else if (in_sret) m_sup = 0;
                if (m_inflight) begin
                    if (in_imem_ready) m_inflight = 0; else m_discard = 1;
                end
            end else if (m_inflight) begin
                if (in_imem_ready) begin
                    m_inflight = 0;
                    if (m_discard) m_discard = 0;
                    else if (m_stall) begin m_pend = 1; m_pend_instr = in_imem_data; end
                    else model_deliver(in_imem_data);
                end
            end else if (m_pend) begin
                if (!m_stall) begin model_deliver(m_pend_instr); m_pend = 0; end
            end else if (!m_fault && m_started) begin
                if (m_pc[1:0] != 2'b00) begin
                    if (!m_stall) begin
                        m_instr = NOP_INSTR; m_ifpc = m_pc; m_vec = EXC_FETCH_MISALIGNED;
                        m_valid = 1; m_fault = 1;
                    end
                end else begin
                    m_inflight = 1; m_addr = m_pc; m_discard = 0;
                end
            end
            m_started = 1;
        end
    end

    function automatic logic exp_req();
        if (!m_started) return 1'b0;
        if (m_inflight) return 1'b1;
        if (m_pend || m_fault) return 1'b0;
        return (m_pc[1:0] == 2'b00) && !(in_exception | in_sret | in_redirect);
    endfunction

    always @(negedge clk) begin
        chk("req", 32'(out_imem_req), 32'(exp_req()));
        if (exp_req()) chk("addr", out_imem_addr, m_inflight ? m_addr : m_pc);
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("instr", out_instruction, m_instr);
        chk("idx", 32'(out_complete_idx), 32'(m_idx));
        chk("vec", 32'(out_exception_vector), 32'(m_vec));
        chk("sup", 32'(out_supervisor_mode), 32'(m_sup));
        if (m_valid) chk("pc", out_PC, m_ifpc);
    end

    task automatic wait_pc(input logic [31:0] target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid && out_PC == target) break;
        end
        chk("wait_pc_timeout", 32'(i < budget), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark;
        reset = 0; in_pc_write_disable = 0; in_IFID_write_disable = 0;
        in_redirect = 0; in_exception = 0; in_sret = 0; in_redirect_pc = 0; in_flush_rob_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr", out_instruction, 32'h0000_0013);
        chk("rst_pc", out_PC, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sup", 32'(out_supervisor_mode), 32'd1);
        chk("rst_req", 32'(out_imem_req), 32'd0);
        cyc(); reset = 1;

        // Back-to-back fetch, no stalls
        wait_pc(32'h1008, 30);
        chk("t1_addr0", req_log[0], 32'h1000);
        chk("t1_addr1", req_log[1], 32'h1004);
        chk("t1_addr2", req_log[2], 32'h1008);
        chk("t1_idx", 32'(out_complete_idx), 32'd3);
        chk("t1_instr", out_instruction, 32'h1008_0513);
        chk("t1_sup", 32'(out_supervisor_mode), 32'd1);

        // Stall across the ready pulse for three cycles
        cyc(); in_IFID_write_disable = 1; lat = 2;
        cyc();
        cyc(); in_IFID_write_disable = 0; in_pc_write_disable = 1;
        @(negedge clk);
        chk("t2_hold_pc", out_PC, 32'h1008);
        chk("t2_hold_req", 32'(out_imem_req), 32'd0);
        cyc(); in_pc_write_disable = 0;
        @(negedge clk);
        chk("t2_not_early", out_PC, 32'h1008);
        @(negedge clk);
        chk("t2_instr", out_instruction, 32'h0050_0093);
        chk("t2_pc", out_PC, 32'h100C);
        chk("t2_idx", 32'(out_complete_idx), 32'd4);
        chk("t2_next_addr", out_imem_addr, 32'h1010);

        // Redirect while waiting on a slow response
        cyc(); in_redirect = 1; in_redirect_pc = 32'h1100; in_flush_rob_idx = 4'd9;
        cyc(); in_redirect = 0; lat = 1;
        @(negedge clk);
        chk("t3_valid", 32'(out_valid), 32'd0);
        chk("t3_idx", 32'(out_complete_idx), 32'd9);
        chk("t3_drain_addr", out_imem_addr, 32'h1010);
        chk("t3_drain_req", 32'(out_imem_req), 32'd1);
        cyc();
        @(negedge clk);
        chk("t3_new_addr", out_imem_addr, 32'h1100);
        chk("t3_discard", 32'(out_valid), 32'd0);
        wait_pc(32'h1100, 10);
        chk("t3_idx_next", 32'(out_complete_idx), 32'd10);

        // Misaligned redirect, coincident with a ready pulse
        cyc(); in_redirect = 1; in_redirect_pc = 32'h1002; in_flush_rob_idx = 4'd3;
        cyc(); in_redirect = 0;
        mark = req_log.size();
        @(negedge clk);
        chk("t4_no_req", 32'(out_imem_req), 32'd0);
        cyc();
        @(negedge clk);
        chk("t4_pc", out_PC, 32'h1002);
        chk("t4_vec", 32'(out_exception_vector), 32'd1);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_idx", 32'(out_complete_idx), 32'd3);
        repeat (3) cyc();
        chk("t4_fault_noreq", 32'(req_log.size()), 32'(mark));
        in_exception = 1; in_flush_rob_idx = 4'd5;
        cyc(); in_exception = 0;
        @(negedge clk);
        chk("t4_exc_addr", out_imem_addr, 32'h2000);
        chk("t4_exc_sup", 32'(out_supervisor_mode), 32'd1);

        // Exception beats redirect; sret leaves supervisor; exception re-enters it
        cyc(); in_exception = 1; in_redirect = 1; in_redirect_pc = 32'h3000;
        cyc(); in_exception = 0; in_redirect = 0;
        @(negedge clk);
        chk("t5_prio_addr", out_imem_addr, 32'h2000);
        cyc(); in_sret = 1;
        cyc(); in_sret = 0;
        @(negedge clk);
        chk("t5_sret_addr", out_imem_addr, 32'h3000);
        chk("t5_sret_sup", 32'(out_supervisor_mode), 32'd0);
        wait_pc(32'h3000, 10);
        chk("t5_instr", out_instruction, 32'h3000_0513);
        cyc(); in_exception = 1;
        cyc(); in_exception = 0;
        @(negedge clk);
        chk("t5_exc_sup", 32'(out_supervisor_mode), 32'd1);
        wait_pc(32'h2000, 10);
        cyc(); in_sret = 1; in_redirect_pc = 32'h1200; lat = 3;
        cyc(); in_sret = 0;
        @(negedge clk);
        chk("t5_sup_off", 32'(out_supervisor_mode), 32'd0);

        // Asynchronous reset in the middle of a wait
        cyc(); #2 reset = 0; #1;
        chk("t6_req", 32'(out_imem_req), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_instr", out_instruction, 32'h0000_0013);
        chk("t6_idx", 32'(out_complete_idx), 32'd0);
        chk("t6_sup", 32'(out_supervisor_mode), 32'd1);
        mark = req_log.size();
        repeat (2) @(posedge clk);
        #1 reset = 1; lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_log.size() > mark) break;
        end
        chk("t6_got_req", 32'(req_log.size() > mark), 32'd1);
        if (req_log.size() > mark) chk("t6_first_addr", req_log[mark], 32'h1000);
        wait_pc(32'h1000, 10);
        chk("t6_idx", 32'(out_complete_idx), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
